// File: rtl/fu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fu_sched_pkg
// Purpose : Shared definitions for the function-unit scheduler: FU bit
//           positions, the per-lane FU mask type and small mask helpers.
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
package fu_sched_pkg;

  localparam int NFU    = 5;
  localparam int FU_ALU = 0;
  localparam int FU_MEM = 1;
  localparam int FU_MUL = 2;
  localparam int FU_DIV = 3;
  localparam int FU_CSR = 4;

  typedef logic [4:0] fu_mask_t;

  // Isolates the lowest set bit (two's-complement trick); 0 stays 0.
  function automatic fu_mask_t lowest_bit(input fu_mask_t m);
    return m & (~m + 5'd1);
  endfunction

  function automatic logic is_onehot(input fu_mask_t m);
    return (m != 5'd0) && ((m & (m - 5'd1)) == 5'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_credit.sv
`default_nettype none
// ============================================================================
// Module  : fu_credit
// Purpose : Credit counter for a downstream queue. Each cycle it subtracts
//           the credits taken and adds the credits returned; refill snaps
//           it back to full (queue flushed).
// Ports   : clk     in   clock
//           rst     in   synchronous active-high reset (count <= MAX)
//           refill  in   restore count to MAX at the next edge
//           take    in   credits consumed this cycle
//           ret     in   credits returned this cycle
//           count   out  current credit count (0..MAX)
//           nonzero out  count != 0
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
module fu_credit #(
  parameter int MAX = 8,
  parameter int TW  = 2,
  parameter int RW  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         refill,
  input  logic [TW-1:0]                take,
  input  logic [RW-1:0]                ret,
  output logic [$clog2(MAX+1)-1:0]     count,
  output logic                         nonzero
);

  localparam int CW = $clog2(MAX+1);
  // Wide enough that neither the return nor the take can wrap before the
  // overflow check sees the true value.
  localparam int SW = CW + RW + 1;

  logic [SW-1:0] sum;

  assign sum     = SW'(count) - SW'(take) + SW'(ret);
  assign nonzero = (count != '0);

  always_ff @(posedge clk) begin
    if (rst || refill) begin
      count <= CW'(MAX);
    end else begin
      count <= sum[CW-1:0];
    end
  end

  // Returning more credits than were ever handed out is an upstream bug.
  always_ff @(posedge clk) begin
    if (!rst && !refill) begin
      assert (sum <= SW'(MAX));
    end
  end

endmodule
`default_nettype wire

// File: rtl/fu_sched.sv
`default_nettype none
// ============================================================================
// Module  : fu_sched
// Purpose : Function-unit scheduler between issue and execute. Each cycle it
//           accepts an in-order prefix of the offered lanes, binds every
//           accepted lane to one FU (lowest available bit of its mask) and
//           tracks FU occupancy: per-cycle ALU/MUL/MEM limits, memory
//           credits, a non-pipelined divider and a serialising CSR unit.
// Ports   : clk        in   clock
//           rst        in   synchronous active-high reset
//           redir      in   pipeline redirect / flush
//           iss_valid  in   [IWD]    lane offers an op
//           iss_fu     in   [IWD*5]  per-lane FU mask, lane i at [i*5 +: 5]
//                                    bits: 0 ALU, 1 MEM, 2 MUL, 3 DIV, 4 CSR
//           issue      out  [IWD]    lane accepted (always a prefix)
//           grant_fu   out  [IWD*5]  one-hot FU bound to each accepted lane
//           fu_ready   out  [5]      per-FU can-accept, from state only
//           mem_ret    in            memory credits returned this cycle
//           csr_done   in   CSR op finished, releases serialisation
//           perf_stall out  [5][32]  stall counters (FUSCHED_PERF_EN only)
// Config  : FUSCHED_PERF_EN - adds perf_stall: counter k counts cycles where
//           a lane is refused solely because FU k is unavailable.
// Revision: 1.0  initial release
// ============================================================================
module fu_sched
  import fu_sched_pkg::*;
#(
  parameter int IWD    = 4,
  parameter int NALU   = 2,
  parameter int MWD    = 2,
  parameter int MCRED  = 8,
  parameter int DIVLAT = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redir,
  input  logic [IWD-1:0]            iss_valid,
  input  logic [IWD*5-1:0]          iss_fu,
  output logic [IWD-1:0]            issue,
  output logic [IWD*5-1:0]          grant_fu,
  output logic [4:0]                fu_ready,
  input  logic [$clog2(MWD+1):0]    mem_ret,
  input  logic                      csr_done
`ifdef FUSCHED_PERF_EN
  ,
  output logic [4:0][31:0]          perf_stall
`endif
);

  localparam int CW = $clog2(MCRED+1);
  localparam int DW = $clog2(DIVLAT+1);
  localparam int TW = $clog2(MWD+1);
  localparam int RW = $clog2(MWD+1) + 1;

  // --------------------------------------------------------------------------
  // Occupancy state
  // --------------------------------------------------------------------------
  logic [CW-1:0] cred;
  logic          cred_nz;
  logic [DW-1:0] divcnt;
  logic          csr_busy;

  // --------------------------------------------------------------------------
  // Grant loop results
  // --------------------------------------------------------------------------
  int       alu_n;
  int       mem_n;
  int       mem_lim;
  logic     mul_g;
  logic     div_g;
  logic     csr_g;
  logic     blocked;
  fu_mask_t mask;
  fu_mask_t avail;
  fu_mask_t pick;
`ifdef FUSCHED_PERF_EN
  logic     stall_vld;
  fu_mask_t stall_mask;
`endif

  // Ready depends on registered state only, so issue may consume it in the
  // same cycle without forming a loop through the issue queue.
  assign fu_ready = {~csr_busy, (divcnt == '0), 1'b1, cred_nz, 1'b1};

  always_comb begin
    issue    = '0;
    grant_fu = '0;
    alu_n    = 0;
    mem_n    = 0;
    mul_g    = 1'b0;
    div_g    = 1'b0;
    csr_g    = 1'b0;
    mask     = '0;
    avail    = '0;
    pick     = '0;
    mem_lim  = (MWD < int'(cred)) ? MWD : int'(cred);
    // Reset and redirect suppress every grant by starting the scan blocked.
    blocked  = rst | redir;
`ifdef FUSCHED_PERF_EN
    stall_vld  = 1'b0;
    stall_mask = '0;
`endif
    for (int i = 0; i < IWD; i++) begin
      mask          = iss_fu[i*5 +: 5];
      avail         = '0;
      avail[FU_ALU] = (alu_n < NALU);
      avail[FU_MEM] = (mem_n < mem_lim);
      avail[FU_MUL] = ~mul_g;
      avail[FU_DIV] = (divcnt == '0) && ~div_g;
      avail[FU_CSR] = (i == 0) && ~csr_busy;
      pick          = lowest_bit(mask & avail);
      if (!blocked) begin
        if (iss_valid[i] && (pick != '0)) begin
          issue[i]          = 1'b1;
          grant_fu[i*5 +: 5] = pick;
          if (pick[FU_ALU]) alu_n = alu_n + 1;
          if (pick[FU_MEM]) mem_n = mem_n + 1;
          if (pick[FU_MUL]) mul_g = 1'b1;
          if (pick[FU_DIV]) div_g = 1'b1;
          // A CSR serialises: nothing younger may issue alongside it.
          if (pick[FU_CSR]) begin
            csr_g   = 1'b1;
            blocked = 1'b1;
          end
        end else begin
          // First refused lane ends the prefix. An all-zero mask lands here
          // too and stalls the lane forever until the mask changes.
          blocked = 1'b1;
`ifdef FUSCHED_PERF_EN
          if (iss_valid[i] && is_onehot(mask)) begin
            stall_vld  = 1'b1;
            stall_mask = mask;
          end
`endif
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory credits; a redirect flushes the load/store queue.
  // --------------------------------------------------------------------------
  fu_credit #(
    .MAX (MCRED),
    .TW  (TW),
    .RW  (RW)
  ) u_cred (
    .clk     (clk),
    .rst     (rst),
    .refill  (redir),
    .take    (TW'(mem_n)),
    .ret     (mem_ret),
    .count   (cred),
    .nonzero (cred_nz)
  );

  // --------------------------------------------------------------------------
  // Divider occupancy and CSR serialisation
  // --------------------------------------------------------------------------
  // divcnt counts the busy cycles left after the grant cycle, so it loads
  // DIVLAT-1: the next DIV is granted exactly DIVLAT cycles after the last.
  // The divider cannot be cancelled, so redirect does not touch divcnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      divcnt   <= '0;
      csr_busy <= 1'b0;
    end else begin
      if (div_g) begin
        divcnt <= DW'(DIVLAT - 1);
      end else if (divcnt != '0) begin
        divcnt <= divcnt - DW'(1);
      end

      // A grant beats a same-cycle csr_done: the done belongs to an older op.
      if (redir) begin
        csr_busy <= 1'b0;
      end else if (csr_g) begin
        csr_busy <= 1'b1;
      end else if (csr_done) begin
        csr_busy <= 1'b0;
      end
    end
  end

`ifdef FUSCHED_PERF_EN
  // Stall counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
    end else begin
      for (int k = 0; k < NFU; k++) begin
        if (stall_vld && stall_mask[k]) begin
          perf_stall[k] <= perf_stall[k] + 32'd1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_fu_sched
// Purpose : Directed self-checking bench for fu_sched (default parameters:
//           IWD=4, NALU=2, MWD=2, MCRED=8, DIVLAT=12).
// Revision: 1.0  initial release
// ============================================================================
module tb_fu_sched;

  localparam logic [4:0] A = 5'b00001;
  localparam logic [4:0] M = 5'b00010;
  localparam logic [4:0] U = 5'b00100;
  localparam logic [4:0] D = 5'b01000;
  localparam logic [4:0] C = 5'b10000;
  localparam logic [4:0] Z = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir;
  logic [3:0]  iss_valid;
  logic [19:0] iss_fu;
  logic [3:0]  issue;
  logic [19:0] grant_fu;
  logic [4:0]  fu_ready;
  logic [2:0]  mem_ret;
  logic        csr_done;
`ifdef FUSCHED_PERF_EN
  logic [4:0][31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fu_sched dut (
    .clk       (clk),
    .rst       (rst),
    .redir     (redir),
    .iss_valid (iss_valid),
    .iss_fu    (iss_fu),
    .issue     (issue),
    .grant_fu  (grant_fu),
    .fu_ready  (fu_ready),
    .mem_ret   (mem_ret),
    .csr_done  (csr_done)
`ifdef FUSCHED_PERF_EN
    ,
    .perf_stall(perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic [3:0] v, input logic [4:0] f0, input logic [4:0] f1,
                       input logic [4:0] f2, input logic [4:0] f3);
    iss_valid = v;
    iss_fu    = {f3, f2, f1, f0};
  endtask

  // Advance one clock; inputs are then changed 2 units after the edge and
  // outputs sampled 1 unit later, well away from either clock edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; redir = 1'b0; mem_ret = '0; csr_done = 1'b0;
    lanes(4'b0000, Z, Z, Z, Z);
    tick(); tick();
    lanes(4'b1111, A, A, A, M);
    #1;
    check("issue_in_rst", 32'(issue), 32'h0);
    check("grant_in_rst", 32'(grant_fu), 32'h0);

    // Reset state, idle
    tick();
    rst = 1'b0;
    lanes(4'b0000, Z, Z, Z, Z);
    #1;
    check("ready_reset", 32'(fu_ready), 32'h1f);
    check("issue_idle", 32'(issue), 32'h0);

    // ALU,ALU,ALU,MEM: third ALU exceeds NALU and blocks the MEM behind it
    tick();
    lanes(4'b1111, A, A, A, M);
    #1;
    check("alu_limit_issue", 32'(issue), 32'h3);
    check("alu_limit_grant", 32'(grant_fu), 32'h00021);

    // ALU, MEM
    tick();
    lanes(4'b0011, A, M, Z, Z);
    #1;
    check("alu_mem_issue", 32'(issue), 32'h3);
    check("alu_mem_grant", 32'(grant_fu), 32'h00041);

    // Mask ALU|MUL with ALUs exhausted binds to MUL; second MUL refused
    tick();
    lanes(4'b1111, A, A, 5'b00101, U);
    #1;
    check("mul_fallback_issue", 32'(issue), 32'h7);
    check("mul_fallback_grant", 32'(grant_fu), 32'h01021);

    // Zero mask on a valid lane stalls it and everything after it
    tick();
    lanes(4'b0111, A, Z, A, Z);
    #1;
    check("zero_mask_issue", 32'(issue), 32'h1);

    // DIV at t
    tick();
    lanes(4'b0001, D, Z, Z, Z);
    #1;
    check("div_ready_before", 32'(fu_ready), 32'h1f);
    check("div_issue_t", 32'(issue), 32'h1);
    check("div_grant_t", 32'(grant_fu), 32'h00008);
    tick();   // t+1
    #1;
    check("div_ready_t1", 32'(fu_ready[3]), 32'h0);
    check("div_refused_t1", 32'(issue), 32'h0);
    for (int k = 2; k <= 10; k++) tick();
    tick();   // t+11
    #1;
    check("div_ready_t11", 32'(fu_ready[3]), 32'h0);
    check("div_refused_t11", 32'(issue), 32'h0);
    tick();   // t+12
    #1;
    check("div_ready_t12", 32'(fu_ready[3]), 32'h1);
    check("div_issue_t12", 32'(issue), 32'h1);

    // Memory credits: 7 left; drain with up to MWD grants per cycle
    tick();
    lanes(4'b1111, M, M, M, M);
    #1;
    check("mem_c7_issue", 32'(issue), 32'h3);
    tick();
    #1;
    check("mem_c5_issue", 32'(issue), 32'h3);
    tick();
    #1;
    check("mem_c3_issue", 32'(issue), 32'h3);
    tick();
    #1;
    check("mem_c1_issue", 32'(issue), 32'h1);
    check("mem_c1_grant", 32'(grant_fu), 32'h00002);
    tick();
    mem_ret = 3'd1;
    #1;
    check("mem_c0_ready", 32'(fu_ready[1]), 32'h0);
    check("mem_c0_issue", 32'(issue), 32'h0);
    tick();
    mem_ret = 3'd0;
    #1;
    check("mem_ret_ready", 32'(fu_ready[1]), 32'h1);
    check("mem_ret_issue", 32'(issue), 32'h1);
    tick();
    lanes(4'b0000, Z, Z, Z, Z);
    mem_ret = 3'd3;
    tick();
    mem_ret = 3'd0;

    // CSR on lane 0 with ALUs behind it: only the CSR issues
    lanes(4'b1111, C, A, A, A);
    #1;
    check("csr_issue", 32'(issue), 32'h1);
    check("csr_grant", 32'(grant_fu), 32'h00010);
    tick();
    #1;
    check("csr_busy_ready", 32'(fu_ready[4]), 32'h0);
    check("csr_busy_issue", 32'(issue), 32'h0);
    lanes(4'b0000, Z, Z, Z, Z);
    for (int k = 0; k < 4; k++) tick();
    // csr busy, divider idle, cred=3
    lanes(4'b0001, D, Z, Z, Z);
    #1;
    check("pre_redir_ready", 32'(fu_ready), 32'h0f);
    check("pre_redir_div", 32'(issue), 32'h1);
    tick();
    lanes(4'b0000, Z, Z, Z, Z);
    for (int k = 0; k < 6; k++) tick();
    // divcnt=5, cred=3, csr_busy=1
    redir = 1'b1;
    lanes(4'b1111, A, A, A, A);
    #1;
    check("redir_ready", 32'(fu_ready), 32'h07);
    check("redir_issue", 32'(issue), 32'h0);
    check("redir_grant", 32'(grant_fu), 32'h0);
    tick();   // R+1: cred=8, csr free, divcnt=4
    redir = 1'b0;
    lanes(4'b1111, M, M, M, M);
    #1;
    check("post_redir_ready", 32'(fu_ready), 32'h17);
    check("post_redir_mem1", 32'(issue), 32'h3);
    tick();
    #1;
    check("post_redir_mem2", 32'(issue), 32'h3);
    tick();
    #1;
    check("post_redir_mem3", 32'(issue), 32'h3);
    tick();   // R+4: divcnt=1
    #1;
    check("post_redir_div_r4", 32'(fu_ready[3]), 32'h0);
    check("post_redir_mem4", 32'(issue), 32'h3);
    tick();   // R+5: divcnt=0, cred=0
    #1;
    check("post_redir_r5_ready", 32'(fu_ready), 32'h1d);
    check("post_redir_mem5", 32'(issue), 32'h0);

    // Refill credits to 8
    lanes(4'b0000, Z, Z, Z, Z);
    mem_ret = 3'd4;
    tick();
    tick();
    mem_ret = 3'd0;

    // CSR on lane 1 is never grantable: lane 0 only
    lanes(4'b0011, A, C, Z, Z);
    #1;
    check("csr_lane1_issue", 32'(issue), 32'h1);
    check("csr_lane1_grant", 32'(grant_fu), 32'h00001);

    // csr_done in the grant cycle leaves csr_busy set
    tick();
    lanes(4'b0001, C, Z, Z, Z);
    csr_done = 1'b1;
    #1;
    check("csr_done_grant_issue", 32'(issue), 32'h1);
    tick();
    csr_done = 1'b0;
    lanes(4'b0000, Z, Z, Z, Z);
    #1;
    check("csr_done_same_cycle", 32'(fu_ready[4]), 32'h0);
    csr_done = 1'b1;
    tick();
    csr_done = 1'b0;
    #1;
    check("csr_done_release", 32'(fu_ready), 32'h1f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
